// File: rtl/mac_seq_ctrl.sv
// Pass sequencer for the MAC column array: array reset, key load stream,
// query execute stream, then drain until the last column has written every result.
module mac_seq_ctrl #(
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int addr_w      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mac_reset,
  output logic [1:0]        inst,
  output logic              kmem_rd,
  output logic              qmem_rd,
  output logic [addr_w-1:0] mem_addr,
  output logic              q_sel,
  input  logic              fifo_wr_last
);

  localparam int cnt_w = $clog2(total_cycle + 1);
  localparam logic [addr_w-1:0] last_k   = addr_w'(col - 1);
  localparam logic [addr_w-1:0] last_q   = addr_w'(total_cycle - 1);
  localparam logic [cnt_w-1:0]  cnt_full = cnt_w'(total_cycle);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARST  = 3'd1,
    KLOAD = 3'd2,
    GAP   = 3'd3,
    EXEC  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t           state;
  logic [cnt_w-1:0] res_cnt;
  logic [cnt_w-1:0] res_cnt_nxt;
  logic             counting;

  // Saturating count of last-column write strobes seen while a pass is running.
  always_comb begin
    counting    = 1'b0;
    res_cnt_nxt = res_cnt;
    if (state == KLOAD || state == GAP || state == EXEC || state == DRAIN) begin
      counting = 1'b1;
    end else begin
      counting = 1'b0;
    end
    if (counting && fifo_wr_last && (res_cnt != cnt_full)) begin
      res_cnt_nxt = res_cnt + cnt_w'(1);
    end else begin
      res_cnt_nxt = res_cnt;
    end
  end

  // Sequencer state and registered outputs; every output reflects the state it is issued in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mac_reset <= 1'b1;
      inst      <= 2'b00;
      kmem_rd   <= 1'b0;
      qmem_rd   <= 1'b0;
      mem_addr  <= '0;
      q_sel     <= 1'b0;
      res_cnt   <= '0;
    end else begin
      q_sel   <= qmem_rd;
      done    <= 1'b0;
      res_cnt <= res_cnt_nxt;
      case (state)
        IDLE: begin
          inst     <= 2'b00;
          kmem_rd  <= 1'b0;
          qmem_rd  <= 1'b0;
          mem_addr <= '0;
          if (start) begin
            state     <= ARST;
            mac_reset <= 1'b1;
            busy      <= 1'b1;
            res_cnt   <= '0;
          end else begin
            mac_reset <= 1'b0;
            busy      <= 1'b0;
          end
        end
        ARST: begin
          // Columns latch a key only once per array reset, so the load stream follows it.
          mac_reset <= 1'b0;
          res_cnt   <= '0;
          mem_addr  <= '0;
          inst      <= 2'b01;
          kmem_rd   <= 1'b1;
          state     <= KLOAD;
        end
        KLOAD: begin
          if (mem_addr == last_k) begin
            state    <= GAP;
            inst     <= 2'b00;
            kmem_rd  <= 1'b0;
            mem_addr <= '0;
          end else begin
            mem_addr <= mem_addr + addr_w'(1);
          end
        end
        GAP: begin
          state    <= EXEC;
          inst     <= 2'b10;
          qmem_rd  <= 1'b1;
          mem_addr <= '0;
        end
        EXEC: begin
          if (mem_addr == last_q) begin
            state    <= DRAIN;
            inst     <= 2'b00;
            qmem_rd  <= 1'b0;
            mem_addr <= '0;
          end else begin
            mem_addr <= mem_addr + addr_w'(1);
          end
        end
        DRAIN: begin
          // Busy stays high through the done cycle, which is spent back in IDLE.
          if (res_cnt_nxt == cnt_full) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            done <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          mac_reset <= 1'b1;
          inst      <= 2'b00;
          kmem_rd   <= 1'b0;
          qmem_rd   <= 1'b0;
          mem_addr  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: cycle-exact sequence checks, a behavioural
// memory/array model for key and query alignment, reset and back-to-back passes.
module tb_mac_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start0, start1;
  int   errors = 0;
  int   checks = 0;

  logic       u0_busy, u0_done, u0_mac_reset, u0_kmem_rd, u0_qmem_rd, u0_q_sel, u0_fifo;
  logic [1:0] u0_inst;
  logic [7:0] u0_addr;
  logic       u1_busy, u1_done, u1_mac_reset, u1_kmem_rd, u1_qmem_rd, u1_q_sel, u1_fifo;
  logic [1:0] u1_inst;
  logic [7:0] u1_addr;

  mac_seq_ctrl #(.col(8), .total_cycle(8), .addr_w(8)) u0 (
    .clk(clk), .reset(reset), .start(start0), .busy(u0_busy), .done(u0_done),
    .mac_reset(u0_mac_reset), .inst(u0_inst), .kmem_rd(u0_kmem_rd), .qmem_rd(u0_qmem_rd),
    .mem_addr(u0_addr), .q_sel(u0_q_sel), .fifo_wr_last(u0_fifo));

  mac_seq_ctrl #(.col(1), .total_cycle(1), .addr_w(8)) u1 (
    .clk(clk), .reset(reset), .start(start1), .busy(u1_busy), .done(u1_done),
    .mac_reset(u1_mac_reset), .inst(u1_inst), .kmem_rd(u1_kmem_rd), .qmem_rd(u1_qmem_rd),
    .mem_addr(u1_addr), .q_sel(u1_q_sel), .fifo_wr_last(u1_fifo));

  // Array model: an execute token reaches the last column's FIFO col+3 cycles after issue.
  logic [10:0] sr0 = '0;
  logic [3:0]  sr1 = '0;
  assign u0_fifo = sr0[10];
  assign u1_fifo = sr1[3];
  always @(posedge clk) begin
    if (u0_mac_reset) sr0 <= '0;
    else              sr0 <= {sr0[9:0], u0_inst[1]};
    if (u1_mac_reset) sr1 <= '0;
    else              sr1 <= {sr1[2:0], u1_inst[1]};
  end

  // Key/query memories with one-cycle read latency feeding the q_in mux.
  logic [15:0] kmem [0:255];
  logic [15:0] qmem [0:255];
  logic [15:0] kdata = '0;
  logic [15:0] qdata = '0;
  logic [15:0] q_in0;
  logic [1:0]  inst0_d = 2'b00;
  int          keys[$];
  int          qs[$];
  assign q_in0 = u0_q_sel ? qdata : kdata;
  always @(posedge clk) begin
    if (u0_kmem_rd) kdata <= kmem[u0_addr];
    if (u0_qmem_rd) qdata <= qmem[u0_addr];
    inst0_d <= u0_inst;
    if (u0_mac_reset) begin
      keys.delete();
      qs.delete();
    end else if (inst0_d == 2'b01) begin
      keys.push_back(int'(q_in0));
    end else if (inst0_d == 2'b10) begin
      qs.push_back(int'(q_in0));
    end
  end

  int which = 0;
  logic       o_busy, o_done, o_mrst, o_krd, o_qrd, o_qsel;
  logic [1:0] o_inst;
  logic [7:0] o_addr;
  assign o_busy = (which == 0) ? u0_busy      : u1_busy;
  assign o_done = (which == 0) ? u0_done      : u1_done;
  assign o_mrst = (which == 0) ? u0_mac_reset : u1_mac_reset;
  assign o_krd  = (which == 0) ? u0_kmem_rd   : u1_kmem_rd;
  assign o_qrd  = (which == 0) ? u0_qmem_rd   : u1_qmem_rd;
  assign o_qsel = (which == 0) ? u0_q_sel     : u1_q_sel;
  assign o_inst = (which == 0) ? u0_inst      : u1_inst;
  assign o_addr = (which == 0) ? u0_addr      : u1_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered one cycle after start was accepted; ends in the done cycle.
  task automatic pass(input int c, input int t, input bit glitch);
    int last;
    bit ld, ex, qs_e;
    last = 6 + 2 * c + t;
    for (int n = 1; n <= last; n++) begin
      ld   = (n >= 2) && (n <= 1 + c);
      ex   = (n >= 3 + c) && (n <= 2 + c + t);
      qs_e = (n - 1 >= 3 + c) && (n - 1 <= 2 + c + t);
      check($sformatf("mac_reset@%0d", n), 32'(o_mrst), 32'(n == 1));
      check($sformatf("inst@%0d", n), 32'(o_inst), ld ? 32'd1 : (ex ? 32'd2 : 32'd0));
      check($sformatf("kmem_rd@%0d", n), 32'(o_krd), 32'(ld));
      check($sformatf("qmem_rd@%0d", n), 32'(o_qrd), 32'(ex));
      if (ld) check($sformatf("kaddr@%0d", n), 32'(o_addr), 32'(n - 2));
      if (ex) check($sformatf("qaddr@%0d", n), 32'(o_addr), 32'(n - 3 - c));
      check($sformatf("q_sel@%0d", n), 32'(o_qsel), 32'(qs_e));
      check($sformatf("busy@%0d", n), 32'(o_busy), 32'd1);
      check($sformatf("done@%0d", n), 32'(o_done), 32'(n == last));
      if (glitch) start0 = (n == 4) || (n == c + 5);
      if (n < last) step();
    end
  endtask

  task automatic check_data(input int base);
    int sk;
    check("keys_n", 32'(keys.size()), 32'd8);
    check("qs_n", 32'(qs.size()), 32'd8);
    sk = 0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("key%0d", k), 32'(keys[k]), 32'(base + k));
      sk += keys[k];
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("query%0d", i), 32'(qs[i]), 32'(i + 2));
      check($sformatf("dot%0d", i), 32'(sk * qs[i]), 32'((8 * base + 28) * (i + 2)));
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      kmem[k] = 16'(k + 1);
      qmem[k] = 16'(k + 2);
    end
    start0 = 1'b0;
    start1 = 1'b0;
    reset  = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_mac_reset", 32'(u0_mac_reset), 32'd1);
    check("rst_mac_reset1", 32'(u1_mac_reset), 32'd1);
    check("rst_busy", 32'(u0_busy), 32'd0);
    check("rst_inst", 32'(u0_inst), 32'd0);
    step();
    check("rst_hold", 32'(u0_mac_reset), 32'd1);
    reset = 1'b1;
    step();
    check("rst_release", 32'(u0_mac_reset), 32'd0);
    check("rst_release1", 32'(u1_mac_reset), 32'd0);
    for (int i = 0; i < 7; i++) step();

    // Single pass with defaults, then data alignment through the array model.
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    pass(8, 8, 1'b0);
    step();
    check("idle_busy", 32'(u0_busy), 32'd0);
    check("idle_done", 32'(u0_done), 32'd0);
    check_data(1);

    // Start pulses inside KLOAD and EXEC must not disturb or queue a pass.
    for (int i = 0; i < 3; i++) step();
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    pass(8, 8, 1'b1);
    start0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("no_requeue_busy%0d", i), 32'(u0_busy), 32'd0);
      check($sformatf("no_requeue_done%0d", i), 32'(u0_done), 32'd0);
    end

    // Asynchronous reset in the middle of EXEC at address 3.
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 13; i++) step();
    check("pre_rst_inst", 32'(u0_inst), 32'd2);
    check("pre_rst_addr", 32'(u0_addr), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("arst_inst", 32'(u0_inst), 32'd0);
    check("arst_qmem_rd", 32'(u0_qmem_rd), 32'd0);
    check("arst_mac_reset", 32'(u0_mac_reset), 32'd1);
    check("arst_busy", 32'(u0_busy), 32'd0);
    check("arst_addr", 32'(u0_addr), 32'd0);
    step();
    reset = 1'b1;
    step();
    check("arst_release", 32'(u0_mac_reset), 32'd0);
    check("arst_idle_busy", 32'(u0_busy), 32'd0);
    for (int i = 0; i < 4; i++) step();
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    pass(8, 8, 1'b0);
    step();
    check_data(1);

    // Smallest configuration: one column, one query.
    which = 1;
    step();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    pass(1, 1, 1'b0);
    step();
    check("c1_idle_busy", 32'(u1_busy), 32'd0);
    which = 0;

    // Back-to-back passes with start held; second pass loads new keys.
    for (int i = 0; i < 3; i++) step();
    start0 = 1'b1;
    step();
    pass(8, 8, 1'b0);
    for (int k = 0; k < 256; k++) kmem[k] = 16'(20 + k);
    step();
    start0 = 1'b0;
    pass(8, 8, 1'b0);
    step();
    check("b2b_idle_busy", 32'(u0_busy), 32'd0);
    check_data(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
